// File: rtl/slot_pkg.sv
// slot_pkg: shared types and constants for the slot-machine reel controller.
// State encoding, display mode field, win codes, reel strides and reel width.
package slot_pkg;

   localparam int unsigned ReelW = 3;

   typedef enum logic [2:0] {
      StIdle,
      StSpin3,
      StSpin2,
      StSpin1,
      StResult
   } state_e;

   // Display mode field, top two bits of the number word
   localparam logic [1:0] ModeIdle = 2'b00;
   localparam logic [1:0] ModeSpin = 2'b01;
   localparam logic [1:0] ModeLose = 2'b10;
   localparam logic [1:0] ModeWin  = 2'b11;

   localparam logic [1:0] WinNone   = 2'd0;
   localparam logic [1:0] WinPair   = 2'd1;
   localparam logic [1:0] WinTriple = 2'd2;

   // Distinct per-reel strides so the reels visibly drift apart while spinning
   localparam logic [ReelW-1:0] Stride0 = 3'd1;
   localparam logic [ReelW-1:0] Stride1 = 3'd3;
   localparam logic [ReelW-1:0] Stride2 = 3'd5;

   function automatic logic [1:0] win_code(input logic [ReelW-1:0] r0,
                                           input logic [ReelW-1:0] r1,
                                           input logic [ReelW-1:0] r2);
      if (r0 == r1 && r1 == r2) begin
         return WinTriple;
      end else if (r0 == r1 || r1 == r2 || r0 == r2) begin
         return WinPair;
      end else begin
         return WinNone;
      end
   endfunction

endpackage

// File: rtl/slot_tick_gen.sv
// slot_tick_gen: free-running divider, tick high on the last count of each period.
// A synchronous clear restarts the period so the first tick lands TICK_DIV cycles later.
module slot_tick_gen #(
   parameter int unsigned TICK_DIV = 2500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CntMax);

   // Next count: clear wins, otherwise wrap at the end of the period
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/slot_reel_ctrl.sv
// slot_reel_ctrl: sequences three reels, stops them in order and holds the result.
// number = {mode[1:0], reel2, reel1, reel0}; all outputs come straight from flops.
// Optional macro SLOT_AUTO_STOP_EN adds an internal stop after 4*MIN_SPIN_STEPS idle ticks.
module slot_reel_ctrl
   import slot_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 2500000,
   parameter int unsigned MIN_SPIN_STEPS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   output logic [10:0] number,
   output logic        busy,
   output logic [1:0]  win,
   output logic        done
);

   localparam int unsigned StepW = (MIN_SPIN_STEPS > 1) ? $clog2(MIN_SPIN_STEPS + 1) : 1;
   localparam logic [StepW-1:0] StepMax = StepW'(MIN_SPIN_STEPS);

   state_e           state_q, state_d;
   logic [ReelW-1:0] reel0_q, reel0_d, reel1_q, reel1_d, reel2_q, reel2_d;
   logic [StepW-1:0] steps_q, steps_d;
   logic [1:0]       mode_q, mode_d, win_q, win_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             run0, run1, run2;
   logic             tick, start_acc, stop_in, stop_ok, auto_stop;

   assign start_acc = start && (state_q == StIdle || state_q == StResult);
   assign stop_ok   = (state_q == StSpin2) || (state_q == StSpin1) ||
                      (state_q == StSpin3 && steps_q == StepMax);
   assign stop_in   = stop || auto_stop;

   slot_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (start_acc),
      .tick (tick)
   );

`ifdef SLOT_AUTO_STOP_EN
   localparam int unsigned AutoTicks = 4 * MIN_SPIN_STEPS;
   localparam int unsigned AutoW = (AutoTicks > 1) ? $clog2(AutoTicks + 1) : 1;
   localparam logic [AutoW-1:0] AutoMax = AutoW'(AutoTicks);

   logic [AutoW-1:0] auto_q, auto_d;

   assign auto_stop = (auto_q == AutoMax);

   // Timeout counter: counts ticks while a stop could be accepted, restarts on every stop
   always_comb begin
      auto_d = auto_q;
      if (start_acc || (stop_in && stop_ok)) begin
         auto_d = '0;
      end else if (tick && stop_ok && auto_q != AutoMax) begin
         auto_d = auto_q + 1'b1;
      end
   end

   // Timeout register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_q <= '0;
      end else begin
         auto_q <= auto_d;
      end
   end
`else
   assign auto_stop = 1'b0;
`endif

   // Next state, reel stepping and registered output values
   always_comb begin
      state_d = state_q;
      reel0_d = reel0_q;
      reel1_d = reel1_q;
      reel2_d = reel2_q;
      steps_d = steps_q;
      mode_d  = mode_q;
      win_d   = win_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      run0    = 1'b0;
      run1    = 1'b0;
      run2    = 1'b0;

      if (tick && steps_q != StepMax) begin
         steps_d = steps_q + 1'b1;
      end

      case (state_q)
         StIdle, StResult: begin
            if (start) begin
               state_d = StSpin3;
               steps_d = '0;
               mode_d  = ModeSpin;
               win_d   = WinNone;
               busy_d  = 1'b1;
            end
         end
         StSpin3: begin
            run0 = 1'b1;
            run1 = 1'b1;
            run2 = 1'b1;
            // Early stops fall through here and are simply dropped
            if (stop_in && stop_ok) begin
               state_d = StSpin2;
               run0    = 1'b0;
            end
         end
         StSpin2: begin
            run1 = 1'b1;
            run2 = 1'b1;
            if (stop_in) begin
               state_d = StSpin1;
               run1    = 1'b0;
            end
         end
         StSpin1: begin
            run2 = 1'b1;
            if (stop_in) begin
               state_d = StResult;
               run2    = 1'b0;
               win_d   = win_code(reel0_q, reel1_q, reel2_q);
               mode_d  = (win_d == WinNone) ? ModeLose : ModeWin;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (tick) begin
         if (run0) reel0_d = reel0_q + Stride0;
         if (run1) reel1_d = reel1_q + Stride1;
         if (run2) reel2_d = reel2_q + Stride2;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         reel0_q <= '0;
         reel1_q <= '0;
         reel2_q <= '0;
         steps_q <= '0;
         mode_q  <= ModeIdle;
         win_q   <= WinNone;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         reel0_q <= reel0_d;
         reel1_q <= reel1_d;
         reel2_q <= reel2_d;
         steps_q <= steps_d;
         mode_q  <= mode_d;
         win_q   <= win_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign number = {mode_q, reel2_q, reel1_q, reel0_q};
   assign busy   = busy_q;
   assign win    = win_q;
   assign done   = done_q;

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// tb_slot_reel_ctrl: directed self-checking bench, TICK_DIV=4, MIN_SPIN_STEPS=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_slot_reel_ctrl;

   logic        clk, rst_n, start, stop;
   logic [10:0] number;
   logic        busy, done;
   logic [1:0]  win;
   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;

   slot_reel_ctrl #(
      .TICK_DIV      (4),
      .MIN_SPIN_STEPS(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .number(number),
      .busy  (busy),
      .win   (win),
      .done  (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] num(input logic [1:0] m, input logic [2:0] r2,
                                       input logic [2:0] r1, input logic [2:0] r0);
      return {m, r2, r1, r0};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) done_cnt++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step(1);
      stop = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      step(2);
      chk("reset_number", number, 11'd0);
      chk("reset_busy", {10'd0, busy}, 11'd0);
      chk("reset_win", {9'd0, win}, 11'd0);
      chk("reset_done", {10'd0, done}, 11'd0);
      rst_n = 1'b1;
      step(1);

      // stop in IDLE is ignored
      pulse_stop();
      chk("idle_stop_number", number, 11'd0);
      chk("idle_stop_busy", {10'd0, busy}, 11'd0);

      // Reset three cycles into SPIN3
      done_cnt = 0;
      pulse_start();
      chk("spin_entry_number", number, num(2'd1, 3'd0, 3'd0, 3'd0));
      chk("spin_entry_busy", {10'd0, busy}, 11'd1);
      step(2);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_number", number, 11'd0);
      chk("midreset_busy", {10'd0, busy}, 11'd0);
      chk("midreset_done", {10'd0, done}, 11'd0);
      step(1);
      rst_n = 1'b1;
      step(2);
      chk("midreset_no_done", 11'(done_cnt), 11'd0);
      chk("midreset_idle_mode", number, 11'd0);

      // Early stop dropped, then stop all reels after tick 2 -> 2/6/2 pair
      done_cnt = 0;
      pulse_start();
      step(1);
      pulse_stop();
      chk("gate_early_stop", number, num(2'd1, 3'd0, 3'd0, 3'd0));
      step(6);
      chk("tick2_reels", number, num(2'd1, 3'd2, 3'd6, 3'd2));
      pulse_stop();
      chk("first_stop_busy", {10'd0, busy}, 11'd1);
      pulse_stop();
      pulse_stop();
      chk("pair_number", number, num(2'd3, 3'd2, 3'd6, 3'd2));
      chk("pair_win", {9'd0, win}, 11'd1);
      chk("pair_busy", {10'd0, busy}, 11'd0);
      chk("pair_done", {10'd0, done}, 11'd1);
      step(1);
      chk("pair_done_drop", {10'd0, done}, 11'd0);
      chk("pair_done_count", 11'(done_cnt), 11'd1);

      // start+stop together in RESULT: start wins, reels resume from 2/6/2
      start = 1'b1;
      stop  = 1'b1;
      step(1);
      start = 1'b0;
      stop  = 1'b0;
      chk("resume_number", number, num(2'd1, 3'd2, 3'd6, 3'd2));
      chk("resume_win_clear", {9'd0, win}, 11'd0);
      step(4);
      chk("resume_tick1", number, num(2'd1, 3'd7, 3'd1, 3'd3));
      pulse_stop();  // only one step since restart: dropped
      step(3);
      chk("resume_tick2", number, num(2'd1, 3'd4, 3'd4, 3'd4));
      pulse_stop();  // accepted -> SPIN2
      pulse_start(); // ignored in SPIN2
      step(1);
      chk("spin2_start_ignored", number, num(2'd1, 3'd4, 3'd4, 3'd4));
      pulse_stop();  // lands on a tick: reel1 holds, reel2 advances by 5
      chk("collision_number", number, num(2'd1, 3'd1, 3'd4, 3'd4));
      pulse_stop();
      chk("collision_result", number, num(2'd3, 3'd1, 3'd4, 3'd4));
      chk("collision_win", {9'd0, win}, 11'd1);

      // Stop all reels after tick 3 -> 3/1/7, no win
      do_reset();
      pulse_start();
      step(12);
      chk("tick3_reels", number, num(2'd1, 3'd7, 3'd1, 3'd3));
      pulse_stop();
      pulse_stop();
      pulse_stop();
      chk("nowin_number", number, num(2'd2, 3'd7, 3'd1, 3'd3));
      chk("nowin_win", {9'd0, win}, 11'd0);
      chk("nowin_busy", {10'd0, busy}, 11'd0);

      // Stop on three consecutive cycles after tick 4 -> 4/4/4 triple
      do_reset();
      done_cnt = 0;
      pulse_start();
      step(16);
      chk("tick4_reels", number, num(2'd1, 3'd4, 3'd4, 3'd4));
      pulse_stop();
      pulse_stop();
      pulse_stop();
      chk("triple_number", number, num(2'd3, 3'd4, 3'd4, 3'd4));
      chk("triple_win", {9'd0, win}, 11'd2);
      step(3);
      chk("triple_done_count", 11'(done_cnt), 11'd1);
      pulse_stop();  // ignored in RESULT
      step(4);
      chk("result_hold", number, num(2'd3, 3'd4, 3'd4, 3'd4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
